uart_tx_ctrl: RTL and testbench
===============================

Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a byte request and steps the TX datapath through start, data, parity and stop bits, one bit per CLK (CLK runs at the baud rate). It drives the datapath capture strobe, the serializer enable and bit index, and the output-mux select that chooses start/data/parity/stop onto TX_OUT. The parity generator and serializer sit downstream and are steered only by this block.

Parameters:
DATA_WIDTH, 8, data bits per frame, range 5..9; Bit_idx width = clog2(DATA_WIDTH).
STOP_BITS, 1, stop bits per frame, 1 or 2.

Ports:
CLK        input   1   transmit clock, one bit time per cycle
RST        input   1   asynchronous reset, active-high
Data_Valid input   1   request: new byte on P_Data this cycle (level, sampled on CLK rise)
PAR_EN     input   1   1 = insert parity bit; sampled only when a request is accepted
Data_Load  output  1   combinational accept strobe; datapath latches P_Data and Parity_Ty on the same edge
Ser_en     output  1   serializer shift enable, high for every data-bit cycle
Bit_idx    output  3   data bit being sent, LSB first, 0..DATA_WIDTH-1 (0 outside DATA)
Mux_sel    output  2   00 start (0), 01 serial data, 10 parity bit, 11 stop/idle (1)
Busy       output  1   high from START through the last STOP cycle

Behaviour:
- Reset (asynchronous, active-high, any time including mid-frame): state = IDLE, bit counter = 0, stop counter = 0, par_en_q = 0. Outputs during/after reset: Mux_sel = 11 (line high), Busy = 0, Ser_en = 0, Bit_idx = 0; Data_Load = 0 while RST is high. No partial frame resumes after release.
- Mux_sel, Busy, Ser_en and Bit_idx are Moore decodes of the registered state and counters. They are glitch-free within a cycle.
- Data_Load = Data_Valid & (state == IDLE, or state == STOP on its last stop cycle). It is the only accept point. Data_Valid in any other cycle is ignored: no queuing, no error flag. The requester must hold Data_Valid until it sees Data_Load.
- On accept: par_en_q <= PAR_EN; next state = START.
- IDLE: Mux_sel = 11, Busy = 0. Stays in IDLE until accept.
- START: 1 cycle; Mux_sel = 00, Busy = 1. Next state = DATA with bit counter = 0.
- DATA: DATA_WIDTH cycles; Mux_sel = 01, Ser_en = 1, Bit_idx = counter. The counter increments each cycle.
  - At counter = DATA_WIDTH-1, the next state is PARITY if par_en_q = 1, otherwise STOP. The counter clears to 0.
- PARITY: 1 cycle; Mux_sel = 10. Next state = STOP.
- STOP: STOP_BITS cycles; Mux_sel = 11, Busy = 1.
  - On the last stop cycle with Data_Valid = 1: accept and go to START. This gives back-to-back frames with no idle gap, and Busy stays high.
  - Otherwise go to IDLE.
- Latency: accept at edge k puts START on the line during cycle k+1.
- Frame length = 1 + DATA_WIDTH + par_en_q + STOP_BITS cycles: 10 for 8N1, 11 for 8E1/8O1, 12 with STOP_BITS = 2 and parity.
- PAR_EN changes mid-frame have no effect. The frame uses par_en_q.
- Unreachable state encodings recover to IDLE on the next edge.

Test Plan:
- Reset, then one request, PAR_EN = 0, P_Data = 0xA5: Data_Load pulses once. Mux_sel sequence = 00, 01 x8 (Bit_idx 0..7), 11, then IDLE. Busy is high for exactly 10 cycles. With the datapath attached, TX_OUT = 0,1,0,1,0,0,1,0,1,1.
- PAR_EN = 1, Parity_Ty = 0, P_Data = 0x07 (odd ones): Mux_sel shows 10 at cycle 10 and the line carries parity 1. Busy is high for 11 cycles. Repeat with Parity_Ty = 1: parity bit = 0.
- Data_Valid held high continuously, 3 frames, PAR_EN = 1: Data_Load pulses at the last STOP cycle of each frame. The next START follows immediately, with no cycle of Mux_sel = 11 outside STOP. Busy stays high for 33 cycles.
- Data_Valid pulsed during DATA bit 3: no Data_Load, and the frame is unaltered. PAR_EN toggled mid-frame: the parity slot follows the value captured at accept.
- RST asserted asynchronously during DATA bit 5 (between clock edges): Mux_sel = 11, Busy = 0, Ser_en = 0 immediately. After release with Data_Valid = 1, a fresh START begins one cycle after accept.
- STOP_BITS = 2, DATA_WIDTH = 7, PAR_EN = 0: Bit_idx 0..6, two cycles of Mux_sel = 11 with Busy = 1, total frame 10 cycles. A back-to-back accept occurs only on the second stop cycle.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: steps the TX datapath through start, data,
// optional parity and stop bits, one bit per CLK, and accepts new bytes only
// while idle or on the last stop cycle so frames can run back to back.
module uart_tx_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Data_Valid,
  input  logic                          PAR_EN,
  output logic                          Data_Load,
  output logic                          Ser_en,
  output logic [$clog2(DATA_WIDTH)-1:0] Bit_idx,
  output logic [1:0]                    Mux_sel,
  output logic                          Busy
);

  localparam int unsigned IDX_W  = $clog2(DATA_WIDTH);
  localparam int unsigned STOP_W = 1;

  localparam logic [IDX_W-1:0]  LAST_BIT  = IDX_W'(DATA_WIDTH - 1);
  localparam logic [STOP_W-1:0] LAST_STOP = STOP_W'(STOP_BITS - 1);

  localparam logic [1:0] MUX_START  = 2'b00;
  localparam logic [1:0] MUX_DATA   = 2'b01;
  localparam logic [1:0] MUX_PARITY = 2'b10;
  localparam logic [1:0] MUX_STOP   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [STOP_W-1:0]  stop_cnt_q, stop_cnt_d;
  logic               par_en_q, par_en_d;
  logic [1:0]         mux_sel_q, mux_sel_d;
  logic               busy_q, busy_d;
  logic               ser_en_q, ser_en_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic               last_stop;
  logic               accept;

  // Accept point: idle, or the final stop cycle for gapless back-to-back frames
  always_comb begin
    last_stop = (state_q == ST_STOP) && (stop_cnt_q == LAST_STOP);
    accept    = Data_Valid && !RST && ((state_q == ST_IDLE) || last_stop);
    Data_Load = accept;
  end

  // Next-state/counter logic, plus output decode from the next state so the
  // outputs come straight from flops
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_en_d   = par_en_q;

    if (accept) begin
      par_en_d = PAR_EN;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d   = ST_DATA;
        bit_cnt_d = '0;
      end
      ST_DATA: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d  = '0;
          stop_cnt_d = '0;
          state_d    = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          bit_cnt_d = bit_cnt_q + IDX_W'(1);
        end
      end
      ST_PARITY: begin
        state_d    = ST_STOP;
        stop_cnt_d = '0;
      end
      ST_STOP: begin
        if (last_stop) begin
          stop_cnt_d = '0;
          state_d    = accept ? ST_START : ST_IDLE;
        end else begin
          stop_cnt_d = stop_cnt_q + STOP_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
        par_en_d   = 1'b0;
      end
    endcase

    mux_sel_d = MUX_STOP;
    busy_d    = 1'b1;
    ser_en_d  = 1'b0;
    bit_idx_d = '0;
    case (state_d)
      ST_IDLE:   busy_d = 1'b0;
      ST_START:  mux_sel_d = MUX_START;
      ST_DATA: begin
        mux_sel_d = MUX_DATA;
        ser_en_d  = 1'b1;
        bit_idx_d = bit_cnt_d;
      end
      ST_PARITY: mux_sel_d = MUX_PARITY;
      ST_STOP:   mux_sel_d = MUX_STOP;
      default:   busy_d = 1'b0;
    endcase
  end

  // State, counters and registered outputs; reset parks the line high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      par_en_q   <= 1'b0;
      mux_sel_q  <= MUX_STOP;
      busy_q     <= 1'b0;
      ser_en_q   <= 1'b0;
      bit_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_en_q   <= par_en_d;
      mux_sel_q  <= mux_sel_d;
      busy_q     <= busy_d;
      ser_en_q   <= ser_en_d;
      bit_idx_q  <= bit_idx_d;
    end
  end

  assign Mux_sel = mux_sel_q;
  assign Busy    = busy_q;
  assign Ser_en  = ser_en_q;
  assign Bit_idx = bit_idx_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: 8-bit/1-stop and 7-bit/2-stop instances.
module tb_uart_tx_ctrl;

  typedef struct packed {
    logic [1:0] mux;
    logic [3:0] idx;
    logic       ser;
    logic       load;
    logic       tx;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       dv1 = 1'b0, pen1 = 1'b0, pty1 = 1'b0;
  logic [7:0] pdata1 = 8'h00;
  logic       dl1, se1, bz1;
  logic [2:0] bi1;
  logic [1:0] ms1;

  logic       dv2 = 1'b0, pen2 = 1'b0, pty2 = 1'b0;
  logic [7:0] pdata2 = 8'h00;
  logic       dl2, se2, bz2;
  logic [2:0] bi2;
  logic [1:0] ms2;

  rec_t q1[$];
  rec_t q2[$];
  rec_t r1, r2;
  logic [8:0] sh1 = '0, sh2 = '0;
  logic       ty1s = 1'b0, ty2s = 1'b0;
  logic       dlp1 = 1'b0, dlp2 = 1'b0;
  int run1 = 0, run2 = 0, last_run1 = 0, last_run2 = 0;
  int n_err = 0, n_chk = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(1)) u_dut1 (
    .CLK(clk), .RST(rst), .Data_Valid(dv1), .PAR_EN(pen1), .Data_Load(dl1),
    .Ser_en(se1), .Bit_idx(bi1), .Mux_sel(ms1), .Busy(bz1)
  );

  uart_tx_ctrl #(.DATA_WIDTH(7), .STOP_BITS(2)) u_dut2 (
    .CLK(clk), .RST(rst), .Data_Valid(dv2), .PAR_EN(pen2), .Data_Load(dl2),
    .Ser_en(se2), .Bit_idx(bi2), .Mux_sel(ms2), .Busy(bz2)
  );

  task automatic cmp(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Even parity for type 0, odd for type 1
  function automatic logic par_bit(input logic [8:0] d, input int dw, input logic ty);
    logic p;
    p = ty;
    for (int i = 0; i < dw; i++) p = p ^ d[i];
    return p;
  endfunction

  // Datapath model: what TX_OUT carries for a given mux select
  function automatic logic line_bit(input logic [1:0] mux, input int idx,
                                    input logic [8:0] d, input int dw, input logic ty);
    case (mux)
      2'b00:   return 1'b0;
      2'b01:   return d[idx];
      2'b10:   return par_bit(d, dw, ty);
      default: return 1'b1;
    endcase
  endfunction

  function automatic void put(input int inst, input rec_t r);
    if (inst == 1) q1.push_back(r);
    else q2.push_back(r);
  endfunction

  // Expected busy-cycle trace of one frame; chain = next byte accepted on last stop
  function automatic void push_frame(input int inst, input logic [8:0] d, input int dw,
                                     input int sb, input logic pe, input logic ty,
                                     input logic chain);
    rec_t r;
    r = '{mux: 2'b00, idx: 4'd0, ser: 1'b0, load: 1'b0, tx: 1'b0};
    put(inst, r);
    for (int i = 0; i < dw; i++) begin
      r = '{mux: 2'b01, idx: 4'(i), ser: 1'b1, load: 1'b0, tx: d[i]};
      put(inst, r);
    end
    if (pe) begin
      r = '{mux: 2'b10, idx: 4'd0, ser: 1'b0, load: 1'b0, tx: par_bit(d, dw, ty)};
      put(inst, r);
    end
    for (int j = 0; j < sb; j++) begin
      r = '{mux: 2'b11, idx: 4'd0, ser: 1'b0, load: chain && (j == sb - 1), tx: 1'b1};
      put(inst, r);
    end
  endfunction

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (bz1) begin
      if (q1.size() == 0) cmp("dut1 busy beyond expected frames", q1.size(), 1);
      else begin
        r1 = q1.pop_front();
        cmp("dut1 mux_sel", int'(ms1), int'(r1.mux));
        cmp("dut1 bit_idx", int'(bi1), int'(r1.idx));
        cmp("dut1 ser_en", int'(se1), int'(r1.ser));
        cmp("dut1 data_load", int'(dl1), int'(r1.load));
        cmp("dut1 tx line", int'(line_bit(ms1, int'(bi1), sh1, 8, ty1s)), int'(r1.tx));
      end
      run1++;
    end else begin
      if (run1 != 0) begin last_run1 = run1; run1 = 0; end
      cmp("dut1 idle mux_sel", int'(ms1), 3);
      cmp("dut1 idle ser_en", int'(se1), 0);
      cmp("dut1 idle bit_idx", int'(bi1), 0);
      cmp("dut1 idle data_load", int'(dl1), int'(dv1 && !rst));
    end
    if (dlp1) cmp("dut1 start after accept", int'({bz1, ms1}), 4);
    if (dl1) begin sh1 = {1'b0, pdata1}; ty1s = pty1; end
    dlp1 = dl1;
  end

  // Monitor for the 7-bit, two-stop instance
  always @(negedge clk) begin
    if (bz2) begin
      if (q2.size() == 0) cmp("dut2 busy beyond expected frames", q2.size(), 1);
      else begin
        r2 = q2.pop_front();
        cmp("dut2 mux_sel", int'(ms2), int'(r2.mux));
        cmp("dut2 bit_idx", int'(bi2), int'(r2.idx));
        cmp("dut2 ser_en", int'(se2), int'(r2.ser));
        cmp("dut2 data_load", int'(dl2), int'(r2.load));
        cmp("dut2 tx line", int'(line_bit(ms2, int'(bi2), sh2, 7, ty2s)), int'(r2.tx));
      end
      run2++;
    end else begin
      if (run2 != 0) begin last_run2 = run2; run2 = 0; end
      cmp("dut2 idle mux_sel", int'(ms2), 3);
      cmp("dut2 idle ser_en", int'(se2), 0);
      cmp("dut2 idle bit_idx", int'(bi2), 0);
      cmp("dut2 idle data_load", int'(dl2), int'(dv2 && !rst));
    end
    if (dlp2) cmp("dut2 start after accept", int'({bz2, ms2}), 4);
    if (dl2) begin sh2 = {1'b0, pdata2}; ty2s = pty2; end
    dlp2 = dl2;
  end

  // Wait (bounded) until the accept strobe is seen, then step past the accepting edge
  task automatic wait_load(input int inst);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((inst == 1) ? dl1 : dl2) && n < 50);
    cmp("data_load seen before timeout", int'(n < 50), 1);
    @(posedge clk); #1;
  endtask

  task automatic req(input int inst, input logic [7:0] d, input logic pe, input logic ty);
    if (inst == 1) begin pdata1 = d; pen1 = pe; pty1 = ty; dv1 = 1'b1; end
    else begin pdata2 = d; pen2 = pe; pty2 = ty; dv2 = 1'b1; end
    wait_load(inst);
    if (inst == 1) dv1 = 1'b0;
    else dv2 = 1'b0;
  endtask

  task automatic wait_bit(input int inst, input int idx);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end
    while (!((inst == 1) ? (se1 && int'(bi1) == idx) : (se2 && int'(bi2) == idx)) && n < 50);
    cmp("data bit reached before timeout", int'(n < 50), 1);
  endtask

  // Wait for idle, then check the busy span and that every expected cycle was seen
  task automatic wait_idle(input int inst, input int exp_run);
    int n;
    n = 0;
    do begin @(negedge clk); #1; n++; end
    while (((inst == 1) ? (bz1 || q1.size() != 0) : (bz2 || q2.size() != 0)) && n < 300);
    cmp("idle before timeout", int'(n < 300), 1);
    cmp("busy span cycles", (inst == 1) ? last_run1 : last_run2, exp_run);
    cmp("expected cycles left", (inst == 1) ? q1.size() : q2.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state; Data_Valid high during reset must not load
    dv1 = 1'b1;
    #12;
    cmp("reset mux_sel", int'(ms1), 3);
    cmp("reset busy", int'(bz1), 0);
    cmp("reset ser_en", int'(se1), 0);
    cmp("reset bit_idx", int'(bi1), 0);
    cmp("reset data_load", int'(dl1), 0);
    cmp("reset dut2 mux_sel", int'(ms2), 3);
    cmp("reset dut2 busy", int'(bz2), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dv1 = 1'b0;
    @(posedge clk); #1;

    // 8N1, 0xA5: line 0,1,0,1,0,0,1,0,1,1; 10 busy cycles
    push_frame(1, 9'h0A5, 8, 1, 1'b0, 1'b0, 1'b0);
    req(1, 8'hA5, 1'b0, 1'b0);
    wait_idle(1, 10);

    // 8E1, 0x07 (three ones): parity 1; then odd: parity 0
    push_frame(1, 9'h007, 8, 1, 1'b1, 1'b0, 1'b0);
    req(1, 8'h07, 1'b1, 1'b0);
    wait_idle(1, 11);
    push_frame(1, 9'h007, 8, 1, 1'b1, 1'b1, 1'b0);
    req(1, 8'h07, 1'b1, 1'b1);
    wait_idle(1, 11);

    // Three back-to-back frames with parity, Data_Valid held: 33 busy cycles
    push_frame(1, 9'h03C, 8, 1, 1'b1, 1'b0, 1'b1);
    push_frame(1, 9'h001, 8, 1, 1'b1, 1'b0, 1'b1);
    push_frame(1, 9'h0FE, 8, 1, 1'b1, 1'b0, 1'b0);
    pdata1 = 8'h3C; pen1 = 1'b1; pty1 = 1'b0; dv1 = 1'b1;
    wait_load(1);
    pdata1 = 8'h01;
    wait_load(1);
    pdata1 = 8'hFE;
    wait_load(1);
    dv1 = 1'b0;
    wait_idle(1, 33);

    // Data_Valid pulse in bit 3 is ignored; PAR_EN dropped after accept keeps parity
    push_frame(1, 9'h05A, 8, 1, 1'b1, 1'b0, 1'b0);
    req(1, 8'h5A, 1'b1, 1'b0);
    pen1 = 1'b0;
    wait_bit(1, 2);
    @(posedge clk); #1; dv1 = 1'b1;
    @(posedge clk); #1; dv1 = 1'b0;
    wait_idle(1, 11);

    // PAR_EN raised after accept of a no-parity frame: still no parity slot
    push_frame(1, 9'h05A, 8, 1, 1'b0, 1'b0, 1'b0);
    req(1, 8'h5A, 1'b0, 1'b0);
    pen1 = 1'b1;
    wait_idle(1, 10);

    // Asynchronous reset in the middle of data bit 5
    push_frame(1, 9'h033, 8, 1, 1'b0, 1'b0, 1'b0);
    req(1, 8'h33, 1'b0, 1'b0);
    wait_bit(1, 4);
    @(posedge clk); #2;
    rst = 1'b1;
    dv1 = 1'b1; pdata1 = 8'hC3; pen1 = 1'b0; pty1 = 1'b0;
    #1;
    cmp("async reset mux_sel", int'(ms1), 3);
    cmp("async reset busy", int'(bz1), 0);
    cmp("async reset ser_en", int'(se1), 0);
    cmp("async reset bit_idx", int'(bi1), 0);
    cmp("async reset data_load", int'(dl1), 0);
    cmp("aborted frame cycles left", q1.size(), 4);
    q1.delete();
    @(negedge clk); #1;
    cmp("aborted frame busy span", last_run1, 6);
    push_frame(1, 9'h0C3, 8, 1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    wait_load(1);
    dv1 = 1'b0;
    wait_idle(1, 10);

    // 7 data bits, 2 stop bits: back-to-back accept only on the second stop cycle
    push_frame(2, 9'h055, 7, 2, 1'b0, 1'b0, 1'b1);
    push_frame(2, 9'h00F, 7, 2, 1'b0, 1'b0, 1'b0);
    pdata2 = 8'h55; pen2 = 1'b0; pty2 = 1'b0; dv2 = 1'b1;
    wait_load(2);
    pdata2 = 8'h0F;
    wait_load(2);
    dv2 = 1'b0;
    wait_idle(2, 20);
    push_frame(2, 9'h07F, 7, 2, 1'b0, 1'b0, 1'b0);
    req(2, 8'h7F, 1'b0, 1'b0);
    wait_idle(2, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1);
  end

endmodule
